// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding imem requests feeding a one-entry decode slot.
// Optional FETCH_MISALIGN_TRAP_EN halts on misaligned redirect targets instead of aligning them.
//
// state  | meaning
// S_REQ  | may issue a fetch at pc when the decode slot can take the reply
// S_WAIT | one request outstanding; kill marks its reply as stale
// S_HALT | parked after a misaligned redirect (trap build only)
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        fetch_misaligned
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic        reply_pending;
  logic        misaligned_redirect;
  logic [31:0] redirect_target;

  assign imem_addr = pc;
  assign imem_req  = reset && (state == S_REQ) && (!id_valid || id_ready) && !redirect_valid;

  // A reply still owed after this cycle must be swallowed once it arrives.
  assign reply_pending = ((state == S_WAIT) || ((state == S_HALT) && kill)) && !imem_rvalid;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q;

  assign misaligned_redirect = |redirect_pc[1:0];
  assign redirect_target     = redirect_pc;
  assign fetch_misaligned    = misaligned_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      misaligned_q <= 1'b0;
    else if (redirect_valid)
      misaligned_q <= misaligned_redirect;
  end
`else
  assign misaligned_redirect = 1'b0;
  assign redirect_target     = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_misaligned    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      id_valid <= 1'b0;
      id_inst  <= NOP;
      id_pc    <= RESET_PC;
    end else if (redirect_valid) begin
      pc       <= redirect_target;
      id_valid <= 1'b0;
      kill     <= reply_pending;
      if (misaligned_redirect)
        state <= S_HALT;
      else if (reply_pending)
        state <= S_WAIT;
      else
        state <= S_REQ;
    end else begin
      if (id_valid && id_ready)
        id_valid <= 1'b0;
      case (state)
        S_REQ: begin
          if (imem_req && imem_ready)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state <= S_REQ;
            kill  <= 1'b0;
            if (!kill) begin
              id_inst  <= imem_rdata;
              id_pc    <= pc;
              id_valid <= 1'b1;
              pc       <= pc + 32'd4;
            end
          end
        end
        S_HALT: begin
          if (imem_rvalid)
            kill <= 1'b0;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address (word aligned).
REQ-006 imem_ready  input  1  memory accepts request this cycle (handshake = imem_req & imem_ready).
REQ-007 imem_rvalid  input  1  read data valid; exactly one per accepted request, at least 1 cycle after acceptance.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 redirect_valid  input  1  branch/jump redirect from execute.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 id_valid  output  1  decode slot holds a valid instruction.
REQ-012 id_ready  input  1  decode consumes slot (transfer = id_valid & id_ready).
REQ-013 id_inst  output  32  instruction word to decode/immediate generation.
REQ-014 id_pc  output  32  address of id_inst.
REQ-015 fetch_misaligned  output  1  sticky misaligned-target flag.

Function
REQ-016 Internal pc register; imem_addr SHALL equal pc combinationally.
REQ-017 FSM states: REQ, WAIT, HALT (HALT reachable only with macro, REQ-030).
REQ-018 REQ: imem_req = 1 only if (slot empty or id_ready = 1) and redirect_valid = 0; on handshake -> WAIT, else stay.
REQ-019 At most one outstanding request; imem_req SHALL be 0 in WAIT and HALT.
REQ-020 WAIT, imem_rvalid = 1, no kill: load id_inst <= imem_rdata, id_pc <= pc, id_valid <= 1, pc <= pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), -> REQ.
REQ-021 Slot on response always free by REQ-018; simultaneous consume and load keeps id_valid = 1 with new data.
REQ-022 Consume without load: id_valid <= 0; id_inst/id_pc hold.
REQ-023 redirect_valid = 1 (any state): pc <= redirect_pc, id_valid <= 0 next cycle, redirect has priority over load and consume.
REQ-024 Redirect in WAIT with no rvalid same cycle: set kill, stay WAIT; the next rvalid is discarded, kill cleared, -> REQ.
REQ-025 Redirect in WAIT with rvalid same cycle: response discarded, -> REQ, kill not set.
REQ-026 Redirect in REQ: no request issued that cycle (REQ-018); next cycle requests redirect_pc.
REQ-027 Minimum latency: request accepted cycle N, rvalid cycle N+1 -> id_valid = 1 at N+2; sustained throughput 1 instruction / 2 cycles.

Reset
REQ-028 While reset = 0: pc = RESET_PC, state = REQ, kill = 0, id_valid = 0, id_inst = 32'h0000_0013 (NOP), id_pc = RESET_PC, fetch_misaligned = 0, imem_req = 0.
REQ-029 Reset asserted mid-WAIT: outstanding response after release SHALL be ignored only if it arrives while reset = 0; memory is reset with the block.

Configuration
REQ-030 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0] != 0 -> fetch_misaligned <= 1, state HALT, pc <= redirect_pc; HALT leaves only on aligned redirect (-> REQ, flag cleared) or reset.
REQ-031 Macro undefined: redirect_pc[1:0] forced to 2'b00 on load, HALT unused, fetch_misaligned tied 0.

Verification
REQ-032 Reset release, imem_ready = 1, 1-cycle rvalid, id_ready = 1 -> id_pc sequence 0x0, 0x4, 0x8, id_valid every 2nd cycle.
REQ-033 id_ready = 0 with slot full -> imem_req = 0, id_inst/id_pc stable; id_ready = 1 -> request next address same cycle.
REQ-034 Redirect to 0x100 while in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> word dropped, next id_pc = 0x100.
REQ-035 Redirect coincident with rvalid and id_ready -> id_valid = 0 next cycle, next request address = redirect_pc.
REQ-036 pc = 0xFFFF_FFFC fetched -> next imem_addr = 0x0000_0000.
REQ-037 FETCH_MISALIGN_TRAP_EN: redirect 0x102 -> fetch_misaligned = 1, imem_req = 0; redirect 0x200 -> flag 0, fetch 0x200; undefined: redirect 0x102 fetches 0x100.
